hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
Parametrised hazard/stall controller for the pipelined RISC-V core, placed in the ID stage.
- Detects load-use data hazards on NUM_SRC source registers.
- Detects single-port memory structural hazards.
- Holds the front-end stalled for a configurable number of cycles, using a counter-driven FSM.
- Arbitrates stalls against branch flushes and drives PC, IF/ID and ID/EX control.

Parameters:
REG_AW, 5, register-address width
NUM_SRC, 2, number of ID-stage source operands compared (2 = rs1/rs2, 3 adds rs3)
LOAD_USE_CYC, 1, stall cycles per load-use hazard (>=1)
MEM_STALL_CYC, 1, stall cycles per EX/MEM memory access (0 disables the structural stall)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs  in  NUM_SRC*REG_AW  ID source registers, packed; src i at [i*REG_AW +: REG_AW]
id_rs_valid  in  NUM_SRC  source i is actually read by the ID instruction
ex_mem_read  in  1  ID/EX instruction is a load
ex_rd  in  REG_AW  ID/EX destination register
mem_access  in  1  EX/MEM instruction performs a MemRead or MemWrite
flush  in  1  branch/jump taken; squash IF/ID and ID/EX
stall  out  1  front-end stall
pc_write_en  out  1  PC update enable
if_id_write_en  out  1  IF/ID register write enable
id_ex_bubble  out  1  insert NOP into ID/EX
if_id_flush  out  1  clear IF/ID

Behaviour:
- lu_hit = ex_mem_read && ex_rd!=0 && OR over i of (id_rs_valid[i] && src i == ex_rd).
- sh_hit = mem_access && MEM_STALL_CYC!=0.
- FSM states: IDLE, STALL. Counter cnt has width $clog2(max(LOAD_USE_CYC,MEM_STALL_CYC)+1).
- Reset (rst=0, async):
  - state=IDLE, cnt=0.
  - While rst is low, outputs are forced to stall=0, pc_write_en=1, if_id_write_en=1, id_ex_bubble=0, if_id_flush=0.
- IDLE, flush=1:
  - stall=0; flush has priority and the hazardous instruction is squashed.
  - Stay in IDLE.
- IDLE, flush=0, lu_hit or sh_hit:
  - stall=1 this cycle, combinationally.
  - N = max of the applicable lengths (LOAD_USE_CYC if lu_hit, MEM_STALL_CYC if sh_hit).
  - If N>1: next state STALL, cnt=N-1. Otherwise remain IDLE.
- STALL:
  - stall=1 regardless of lu_hit/sh_hit; no re-trigger or extension.
  - cnt decrements each cycle. At cnt==1, next state is IDLE with cnt=0.
  - Total stall length is exactly N cycles.
- STALL, flush=1: stall=0 that cycle; next state IDLE, cnt=0 (abort).
- Back-to-back hazard: a new hazard seen in the first IDLE cycle after STALL starts a fresh N-cycle stall. There are no gaps and no merging beyond this.
- Output equations:
  - pc_write_en = if_id_write_en = ~stall
  - id_ex_bubble = stall | flush
  - if_id_flush = flush
- Zero-latency: all outputs are combinational from the current state and inputs. No output is registered.
- ex_rd==0 never causes a load-use stall. Sources with id_rs_valid=0 are never compared.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds outputs lu_stall_cnt[31:0] and sh_stall_cnt[31:0].
  - Each counts cycles with stall=1 attributed to its hazard type. When an entry has both hits, the cycles go to sh_stall_cnt.
  - Counters wrap at 2^32 and are reset to 0 by rst.
- Undefined: no ports and no counter logic.

Decomposition:
- Package hazard_pkg: state enum (IDLE, STALL), REG_AW default, and a max_len constant function for the counter width.
- Sub-module hazard_src_match (parametrised NUM_SRC, REG_AW): produces lu_hit from id_rs, id_rs_valid, ex_rd and ex_mem_read.

Test Plan:
- Defaults; ex_mem_read=1, ex_rd=5, id_rs={rs2=7, rs1=5} valid=2'b11 -> stall=1, pc_write_en=0, id_ex_bubble=1 for exactly 1 cycle; next cycle all deasserted.
- ex_rd=0 with rs1=0 valid, ex_mem_read=1 -> stall=0. rs2=9 matching but id_rs_valid[1]=0 -> stall=0.
- LOAD_USE_CYC=3, lu_hit pulsed for one cycle -> stall high for exactly 3 consecutive cycles; state sequence IDLE, STALL (cnt 2), STALL (cnt 1), then IDLE.
- MEM_STALL_CYC=2, LOAD_USE_CYC=3, lu_hit and sh_hit in the same cycle -> 3-cycle stall. With HAZARD_PERF_CNT_EN defined: sh_stall_cnt=3, lu_stall_cnt=0.
- LOAD_USE_CYC=4, flush=1 in the 2nd stall cycle -> stall=0, if_id_flush=1, id_ex_bubble=1 that cycle; IDLE next cycle.
- rst dropped to 0 mid-STALL (asynchronously, between clock edges) -> immediately stall=0, pc_write_en=1. After release, no residual stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared types and helpers for the ID-stage hazard/stall controller.
//   hz_state_t  : controller FSM state (IDLE, STALL)
//   REG_AW_DEF  : default register-address width
//   max_len()   : larger of two stall lengths, used to size the stall counter
package hazard_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } hz_state_t;

    localparam int REG_AW_DEF = 5;

    function automatic int max_len(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match
// Load-use comparator: flags when the load sitting in ID/EX writes a register
// that the ID-stage instruction actually reads.
// Ports:
//   id_rs        in  packed ID source registers, src i at [i*REG_AW +: REG_AW]
//   id_rs_valid  in  per-source "is read" qualifiers
//   ex_rd        in  ID/EX destination register
//   ex_mem_read  in  ID/EX instruction is a load
//   lu_hit       out load-use hazard detected
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int REG_AW  = REG_AW_DEF
) (
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_valid,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_mem_read,
    output logic                      lu_hit
);

    logic [NUM_SRC-1:0] src_hit;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_hit[gi] = id_rs_valid[gi] && (id_rs[gi*REG_AW +: REG_AW] == ex_rd);
        end
    endgenerate

    // x0 is hardwired to zero, so a load "to x0" never produces a dependency.
    assign lu_hit = ex_mem_read && (ex_rd != '0) && (|src_hit);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
// ID-stage hazard/stall controller. Detects load-use and single-port memory
// structural hazards, holds the front end for a configurable number of cycles
// and arbitrates stalls against branch flushes. All outputs are combinational
// from the current state and inputs.
// Optional feature macro: HAZARD_PERF_CNT_EN adds per-cause stall-cycle counters.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   id_rs           packed ID source registers
//   id_rs_valid     per-source read qualifiers
//   ex_mem_read     ID/EX instruction is a load
//   ex_rd           ID/EX destination register
//   mem_access      EX/MEM instruction uses the data memory
//   flush           taken branch/jump
//   stall           front-end stall
//   pc_write_en     PC update enable
//   if_id_write_en  IF/ID write enable
//   id_ex_bubble    insert NOP into ID/EX
//   if_id_flush     clear IF/ID
//   lu_stall_cnt    (HAZARD_PERF_CNT_EN) stall cycles charged to load-use
//   sh_stall_cnt    (HAZARD_PERF_CNT_EN) stall cycles charged to structural
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW        = REG_AW_DEF,
    parameter int NUM_SRC       = 2,
    parameter int LOAD_USE_CYC  = 1,
    parameter int MEM_STALL_CYC = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_valid,
    input  logic                      ex_mem_read,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      mem_access,
    input  logic                      flush,
    output logic                      stall,
    output logic                      pc_write_en,
    output logic                      if_id_write_en,
    output logic                      id_ex_bubble,
    output logic                      if_id_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               lu_stall_cnt,
    output logic [31:0]               sh_stall_cnt
`endif
);

    localparam int MAX_LEN = max_len(LOAD_USE_CYC, MEM_STALL_CYC);
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] LU_LEN   = CNT_W'(LOAD_USE_CYC);
    localparam logic [CNT_W-1:0] SH_LEN   = CNT_W'(MEM_STALL_CYC);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    hz_state_t        state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             lu_hit;
    logic             sh_hit;
    logic [CNT_W-1:0] lu_len_sel, sh_len_sel, hit_len;
    logic             stall_int;
    logic             flush_eff;

    hazard_src_match #(
        .NUM_SRC (NUM_SRC),
        .REG_AW  (REG_AW)
    ) u_src_match (
        .id_rs       (id_rs),
        .id_rs_valid (id_rs_valid),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .lu_hit      (lu_hit)
    );

    // A zero structural length means the memory is not a shared resource.
    assign sh_hit = (MEM_STALL_CYC != 0) && mem_access;

    // Stall length when both hazards coincide is the longer of the two.
    assign lu_len_sel = lu_hit ? LU_LEN : CNT_ZERO;
    assign sh_len_sel = sh_hit ? SH_LEN : CNT_ZERO;
    assign hit_len    = (lu_len_sel > sh_len_sel) ? lu_len_sel : sh_len_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // The first stall cycle is raised combinationally from IDLE; STALL only
    // covers the remaining N-1 cycles, so cnt holds cycles still to go there.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        stall_int  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!flush && (lu_hit || sh_hit)) begin
                    stall_int = 1'b1;
                    if (hit_len > CNT_ONE) begin
                        state_next = STALL;
                        cnt_next   = hit_len - CNT_ONE;
                    end
                end
            end
            STALL: begin
                if (flush) begin
                    // Flush squashes the stalled instruction; abort the stall.
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    stall_int = 1'b1;
                    if (cnt_reg == CNT_ONE) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg - CNT_ONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs are forced to the "pipeline running" values while reset is
    // asserted, independent of whatever the inputs show.
    assign stall          = rst & stall_int;
    assign flush_eff      = rst & flush;
    assign pc_write_en    = ~stall;
    assign if_id_write_en = ~stall;
    assign id_ex_bubble   = stall | flush_eff;
    assign if_id_flush    = flush_eff;

`ifdef HAZARD_PERF_CNT_EN
    // Cause of the stall in progress; structural wins when both fired.
    logic cause_sh_reg, cause_sh_next;
    logic sh_attr;

    assign cause_sh_next = ((state_reg == IDLE) && stall_int) ? sh_hit : cause_sh_reg;
    assign sh_attr       = (state_reg == IDLE) ? sh_hit : cause_sh_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cause_sh_reg <= 1'b0;
            lu_stall_cnt <= '0;
            sh_stall_cnt <= '0;
        end else begin
            cause_sh_reg <= cause_sh_next;
            if (stall_int) begin
                if (sh_attr) begin
                    sh_stall_cnt <= sh_stall_cnt + 32'd1;
                end else begin
                    lu_stall_cnt <= lu_stall_cnt + 32'd1;
                end
            end
        end
    end
`endif

endmodule
